pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage pipeline (if_id, id_ex, ex_mem, mem_wb).
//  Detects load-use hazards, squashes wrong-path fetch on taken branch/jump
//  (resolved in ID), and freezes the pipe while data memory is busy, with timeout.
//  Drives write-enable and flush of every pipeline register and the PC.
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles before the error state (>=2)
//  CNT_W        32  width of the stall_cnt and flush_cnt counters
// PORTS
//  clock          in   1      single clock; all state on posedge
//  reset          in   1      asynchronous, active-high
//  id_rs, id_rt   in   5      source registers of the instruction in ID
//  id_uses_rt     in   1      ID instruction reads rt as an operand
//  id_branch_tkn  in   1      ID resolved taken branch, or jump/jal
//  ex_mem_read    in   1      instruction in EX is a load
//  ex_write_reg   in   5      destination register of the EX instruction
//  mem_req        in   1      MEM-stage load/store is active this cycle
//  mem_ready      in   1      data memory completes the access this cycle
//  pc_write       out  1      PC update enable
//  if_id_write    out  1      if_id hold when 0
//  if_id_flush    out  1      if_id loads a bubble (all zero)
//  id_ex_flush    out  1      id_ex loads a bubble (reg_write=0, mem ctl=0)
//  ex_mem_write   out  1      ex_mem hold when 0
//  mem_wb_flush   out  1      mem_wb loads a bubble
//  mem_err        out  1      sticky timeout flag
//  stall_cnt      out  CNT_W  cycles with pc_write=0 (saturating)
//  flush_cnt      out  CNT_W  cycles with if_id_flush=1 (saturating)
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, ERR. Reset -> RUN, wait_cnt=0, mem_err=0, counters=0.
//  - While reset is high, outputs: pc_write=0, if_id_write=0, all flushes=1, ex_mem_write=0.
//  - mem_stall = mem_req & ~mem_ready. Enter MEM_WAIT from RUN when mem_stall.
//  - lu_hazard = ex_mem_read & ex_write_reg!=0 &
//    (ex_write_reg==id_rs | (id_uses_rt & ex_write_reg==id_rt)).
//  - Priority, evaluated every cycle (combinational from state and inputs):
//    1. ERR: pc_write=0, if_id_write=0, ex_mem_write=0, id_ex_flush=1, mem_wb_flush=1.
//    2. mem_stall: pc_write=0, if_id_write=0, ex_mem_write=0, id_ex_flush=0
//       (id_ex held by its own enable = ex_mem_write), mem_wb_flush=1.
//    3. lu_hazard: pc_write=0, if_id_write=0, id_ex_flush=1; ex_mem/mem_wb advance.
//    4. id_branch_tkn: if_id_flush=1, pc_write=1; all else advance.
//    5. Otherwise all enables=1, all flushes=0.
//  - A taken branch coinciding with lu_hazard or mem_stall is ignored that cycle.
//    ID re-presents it after the stall; no flush is issued early.
//  - MEM_WAIT: wait_cnt increments each cycle with mem_stall.
//    mem_ready=1 -> RUN, wait_cnt=0; the pipe advances in that same cycle.
//    wait_cnt==MEM_TIMEOUT-1 with mem_stall -> ERR and mem_err=1.
//    mem_req dropping without mem_ready -> RUN (request withdrawn).
//  - ERR is left only by reset.
//  - A single-cycle access (mem_req & mem_ready) never leaves RUN.
//  - Counters increment by 1 per qualifying cycle and saturate at all-ones; they do not count in ERR.
//  - Reset mid-MEM_WAIT: state, wait_cnt and flags clear immediately (async).
// STRUCTURE
//  - Shared package pipe_pkg: state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2)
//    and the REG_ZERO=5'd0 constant.
//  - One sub-module, hazard_detect: combinational lu_hazard from ID/EX fields.
//  - The FSM, wait counter and perf counters stay in pipe_ctrl.
// TESTING
//  - Reset pulse mid-operation -> async clear: mem_err=0, stall_cnt=0, outputs at reset values.
//  - ex_mem_read=1, ex_write_reg=8, id_rs=8 -> one cycle: pc_write=0, id_ex_flush=1, stall_cnt+1.
//  - Same case with ex_write_reg=0 -> no stall.
//  - id_uses_rt=0, rt match only -> no stall.
//  - id_branch_tkn=1 alone -> if_id_flush=1 one cycle, flush_cnt+1.
//    With lu_hazard also high -> if_id_flush=0.
//  - mem_req=1, mem_ready=0 for 3 cycles then 1 -> pc_write=0 and mem_wb_flush=1 for 3 cycles,
//    then all enables=1, state RUN, stall_cnt=3.
//  - mem_req=1, mem_ready=0 held for MEM_TIMEOUT cycles -> mem_err=1, state ERR, pipe frozen.
//    Only reset clears it.
//  - Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt=4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_t  : sequencer state encoding
//   REG_ZERO : hard-wired zero register (never a real dependency)
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   id_rs, id_rt   : source registers of the instruction in ID
//   id_uses_rt     : ID instruction actually reads rt
//   ex_mem_read    : EX instruction is a load
//   ex_write_reg   : EX destination register
//   lu_hazard      : ID needs a value the EX load has not produced yet
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_write_reg,
   output logic       lu_hazard
);

   always_comb begin
      lu_hazard = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                  ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   clock, reset          : single clock, async active-high reset
//   id_*/ex_*             : hazard inputs from ID and EX
//   mem_req, mem_ready    : data-memory handshake of the MEM stage
//   pc_write .. mem_wb_flush : enables/flushes of PC and pipeline registers
//   mem_err               : sticky memory timeout flag
//   stall_cnt, flush_cnt  : saturating perf counters
//
// state    | meaning
// RUN      | normal operation, no outstanding slow memory access
// MEM_WAIT | data memory busy, pipe frozen, timeout counting
// ERR      | memory timed out, pipe frozen until reset
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch_tkn,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_write_reg,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int            WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              err_nxt;
   logic              lu_hazard;
   logic              mem_stall;
   logic              stall_inc, flush_inc;

   hazard_detect u_hazard (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_mem_read  (ex_mem_read),
      .ex_write_reg (ex_write_reg),
      .lu_hazard    (lu_hazard)
   );

   assign mem_stall = mem_req && !mem_ready;

   // The stalled cycle that moves RUN -> MEM_WAIT already counts as one wait
   // cycle, so MEM_TIMEOUT consecutive stalled cycles reach ERR.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      err_nxt   = mem_err;
      unique case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt = MEM_WAIT;
               wait_nxt  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!mem_stall) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = ERR;
               err_nxt   = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = ERR;
      endcase
   end

   // Stall decisions key off mem_stall rather than the state, so the cycle
   // mem_ready arrives the pipe already advances.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_flush = 1'b0;
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (state == ERR) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_write = 1'b0;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (mem_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (lu_hazard) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (id_branch_tkn) begin
         if_id_flush = 1'b1;
      end
   end

   assign stall_inc = (state != ERR) && !pc_write;
   assign flush_inc = (state != ERR) && if_id_flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         mem_err  <= err_nxt;
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   localparam int MEM_TIMEOUT = 16;

   logic        clock;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_write_reg;
   logic        id_uses_rt, id_branch_tkn, ex_mem_read, mem_req, mem_ready;

   logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_flush, mem_err;
   logic [31:0] stall_cnt, flush_cnt;
   logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_write, s_mem_wb_flush, s_mem_err;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) u_dut (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_tkn(id_branch_tkn), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
      .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) u_small (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_tkn(id_branch_tkn), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
      .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_write(s_ex_mem_write),
      .mem_wb_flush(s_mem_wb_flush), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_flush}
   localparam logic [5:0] O_RUN   = 6'b110010;
   localparam logic [5:0] O_LU    = 6'b000110;
   localparam logic [5:0] O_BR    = 6'b111010;
   localparam logic [5:0] O_MEM   = 6'b000001;
   localparam logic [5:0] O_ERR   = 6'b000101;
   localparam logic [5:0] O_RESET = 6'b001101;

   logic [5:0] dut_out, small_out;
   assign dut_out   = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_flush};
   assign small_out = {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_write, s_mem_wb_flush};

   int n_pass = 0;
   int n_total = 0;

   // Reference model: err flag, run length of consecutive stalled memory
   // cycles, and plain integer event counts with saturation limits.
   bit     m_err;
   int     m_run;
   longint m_stall, m_flush;
   int     m_stall4, m_flush4;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [5:0] model_out();
      bit stall, haz;
      stall = mem_req && !mem_ready;
      haz   = ex_mem_read && (ex_write_reg != 5'd0) &&
              ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
      if (m_err)         return O_ERR;
      if (stall)         return O_MEM;
      if (haz)           return O_LU;
      if (id_branch_tkn) return O_BR;
      return O_RUN;
   endfunction

   task automatic model_clear();
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic br,
                         input logic mrd, input logic [4:0] wr, input logic req, input logic rdy);
      id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch_tkn = br;
      ex_mem_read = mrd; ex_write_reg = wr; mem_req = req; mem_ready = rdy;
   endtask

   // Checks one cycle at the negedge, then advances the model and the clock.
   task automatic tick(input string name, input bit use_tbl, input logic [5:0] tbl_exp);
      logic [5:0] mo;
      @(negedge clock);
      mo = model_out();
      check({name, " outs"}, dut_out, use_tbl ? tbl_exp : mo);
      check({name, " outs_w4"}, small_out, mo);
      check({name, " mem_err"}, mem_err, m_err);
      check({name, " stall_cnt"}, stall_cnt, m_stall);
      check({name, " flush_cnt"}, flush_cnt, m_flush);
      check({name, " stall_cnt_w4"}, s_stall_cnt, m_stall4);
      check({name, " flush_cnt_w4"}, s_flush_cnt, m_flush4);
      if (!m_err) begin
         if (!mo[5]) begin
            if (m_stall < 64'hFFFF_FFFF) m_stall++;
            if (m_stall4 < 15) m_stall4++;
         end
         if (mo[3]) begin
            if (m_flush < 64'hFFFF_FFFF) m_flush++;
            if (m_flush4 < 15) m_flush4++;
         end
         if (mem_req && !mem_ready) begin
            m_run++;
            if (m_run >= MEM_TIMEOUT) m_err = 1;
         end else begin
            m_run = 0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   // Asserted away from any clock edge, so clearing must be asynchronous.
   task automatic do_reset(input string name);
      reset = 1'b1;
      #1;
      model_clear();
      check({name, " outs"}, dut_out, O_RESET);
      check({name, " mem_err"}, mem_err, 1'b0);
      check({name, " stall_cnt"}, stall_cnt, 0);
      check({name, " flush_cnt"}, flush_cnt, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [4:0] rs, rt;
      logic       urt, br, mrd;
      logic [4:0] wr;
      logic       req, rdy;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, O_RUN};
      tbl[1]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, O_LU};
      tbl[2]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, O_RUN};
      tbl[3]  = '{5'd3,  5'd8,  1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, O_RUN};
      tbl[4]  = '{5'd3,  5'd8,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, O_LU};
      tbl[5]  = '{5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, O_BR};
      tbl[6]  = '{5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, O_LU};
      tbl[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, O_RUN};
      tbl[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, O_MEM};
      tbl[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, O_RUN};
      tbl[10] = '{5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, O_MEM};
      tbl[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, O_RUN};
      tbl[12] = '{5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, O_LU};

      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      model_clear();
      #2;
      do_reset("init_reset");

      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].br, tbl[i].mrd, tbl[i].wr, tbl[i].req, tbl[i].rdy);
         tick($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
      end

      // Three busy cycles then completion.
      do_reset("memwait_reset");
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 1, 0);
         tick("memwait_busy", 1'b1, O_MEM);
      end
      set_in(0, 0, 0, 0, 0, 0, 1, 1);
      tick("memwait_done", 1'b1, O_RUN);
      check("memwait stall_cnt", stall_cnt, 3);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick("memwait_after", 1'b1, O_RUN);

      // Branch alone, then branch masked by a load-use stall.
      do_reset("branch_reset");
      set_in(0, 0, 0, 1, 0, 0, 0, 0);
      tick("branch", 1'b1, O_BR);
      check("branch flush_cnt", flush_cnt, 1);
      set_in(5, 0, 0, 1, 1, 5, 0, 0);
      tick("branch_lu", 1'b1, O_LU);
      check("branch_lu flush_cnt", flush_cnt, 1);

      // Timeout into ERR; only reset recovers.
      do_reset("timeout_reset");
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 1, 0);
         tick("timeout_busy", 1'b1, O_MEM);
      end
      check("timeout mem_err", mem_err, 1'b1);
      set_in(0, 0, 0, 1, 0, 0, 1, 1);
      tick("err_frozen", 1'b1, O_ERR);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick("err_frozen2", 1'b1, O_ERR);
      check("err stall_cnt", stall_cnt, MEM_TIMEOUT);
      do_reset("err_midcycle_reset");
      tick("after_err", 1'b1, O_RUN);

      // Reset in the middle of a memory wait.
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      tick("pre_reset_busy", 1'b1, O_MEM);
      tick("pre_reset_busy2", 1'b1, O_MEM);
      do_reset("memwait_midcycle_reset");
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick("post_reset", 1'b1, O_RUN);

      // Saturation of the 4-bit counters.
      do_reset("sat_reset");
      for (int i = 0; i < 20; i++) begin
         set_in(7, 0, 0, 1, 1, 7, 0, 0);
         tick("sat_stall", 1'b1, O_LU);
      end
      check("sat stall_cnt_w4", s_stall_cnt, 4'hF);
      check("sat stall_cnt_w32", stall_cnt, 20);

      // Random traffic against the model.
      do_reset("rand_reset");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset("rand_midreset");
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 3), 1'($urandom));
         tick("rand", 1'b0, 6'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
